// File: rtl/ras_pkg.sv
// Shared definitions for the return-address queue and the RAS checker.
//   ras_mode_e  : ordering of the queue (FIFO queue or LIFO stack)
//   ras_addr_w  : pointer width for a given power-of-two depth
package ras_pkg;

  typedef enum logic {
    RAS_FIFO,
    RAS_LIFO
  } ras_mode_e;

  function automatic int unsigned ras_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ras_ram.sv
// Storage array for ras_queue: DEPTH x WIDTH, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : combinational read data
module ras_ram
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 36,
  localparam int unsigned ADDR = ras_addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ras_queue.sv
// Return-address queue running in FIFO or LIFO order, with occupancy count,
// full/empty, selectable overflow policy and sticky error flags. When empty,
// dout bypasses din so a same-cycle push+pop passes straight through.
//   clk, rst   : clock, asynchronous active-low reset
//   push, din  : write request and data
//   pop        : consume the current dout
//   dout       : head (FIFO) / top (LIFO) entry, or din when empty
//   empty/full : registered occupancy flags
//   count      : registered occupancy
//   overflow   : sticky, push while full without pop
//   underflow  : sticky, pop while empty without push
//   clr_err    : synchronous clear of both sticky flags (set wins)
module ras_queue
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WIDTH     = 36,
  parameter ras_mode_e   MODE      = RAS_FIFO,
  parameter bit          OVERWRITE = 1'b0,
  localparam int unsigned ADDR     = ras_addr_w(DEPTH),
  localparam int unsigned CW       = ADDR + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  // In LIFO mode wptr is the stack pointer tp and rptr stays at zero.
  logic [ADDR-1:0] rptr_q, rptr_d;
  logic [ADDR-1:0] wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, full_q, ovf_q, ovf_d, unf_q, unf_d;

  logic             ram_we;
  logic [ADDR-1:0]  ram_waddr;
  logic [ADDR-1:0]  ram_raddr;
  logic [WIDTH-1:0] ram_rdata;
  logic             is_empty, is_full, ovf_set, unf_set;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCount);

  always_comb begin
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    ram_we    = 1'b0;
    ram_waddr = wptr_q;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    if (push && pop) begin
      // When empty this is a pure pass-through via the bypass.
      if (!is_empty) begin
        ram_we = 1'b1;
        if (MODE == RAS_FIFO) begin
          wptr_d = wptr_q + 1'b1;
          rptr_d = rptr_q + 1'b1;
        end else begin
          ram_waddr = wptr_q - 1'b1;  // replace top in place
        end
      end
    end else if (push) begin
      if (!is_full) begin
        ram_we  = 1'b1;
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
      end else begin
        ovf_set = 1'b1;
        if (OVERWRITE) begin
          // FIFO: drop the head. LIFO: tp wraps onto the bottom entry.
          ram_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (MODE == RAS_FIFO) begin
            rptr_d = rptr_q + 1'b1;
          end
        end
      end
    end else if (pop) begin
      if (!is_empty) begin
        count_d = count_q - 1'b1;
        if (MODE == RAS_FIFO) begin
          rptr_d = rptr_q + 1'b1;
        end else begin
          wptr_d = wptr_q - 1'b1;
        end
      end else begin
        unf_set = 1'b1;
      end
    end

    ovf_d = ovf_set | (ovf_q & ~clr_err);
    unf_d = unf_set | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FullCount);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign ram_raddr = (MODE == RAS_LIFO) ? (wptr_q - 1'b1) : rptr_q;

  ras_ram #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (din),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign dout      = empty_q ? din : ram_rdata;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_ras_queue.sv
// Self-checking bench for ras_queue. Four DEPTH=4 instances share stimulus:
//   0 = FIFO reject, 1 = FIFO overwrite, 2 = LIFO reject, 3 = LIFO overwrite.
module tb_ras_queue;
  import ras_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] dout [4];
  logic       empty [4];
  logic       full [4];
  logic [2:0] count [4];
  logic       ovf [4];
  logic       unf [4];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic [7:0] e;

  always #5 clk = ~clk;

  ras_queue #(.DEPTH(4), .WIDTH(8), .MODE(RAS_FIFO), .OVERWRITE(1'b0)) u_f0 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .dout(dout[0]),
    .empty(empty[0]), .full(full[0]), .count(count[0]), .overflow(ovf[0]),
    .underflow(unf[0]), .clr_err(clr_err));
  ras_queue #(.DEPTH(4), .WIDTH(8), .MODE(RAS_FIFO), .OVERWRITE(1'b1)) u_f1 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .dout(dout[1]),
    .empty(empty[1]), .full(full[1]), .count(count[1]), .overflow(ovf[1]),
    .underflow(unf[1]), .clr_err(clr_err));
  ras_queue #(.DEPTH(4), .WIDTH(8), .MODE(RAS_LIFO), .OVERWRITE(1'b0)) u_l0 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .dout(dout[2]),
    .empty(empty[2]), .full(full[2]), .count(count[2]), .overflow(ovf[2]),
    .underflow(unf[2]), .clr_err(clr_err));
  ras_queue #(.DEPTH(4), .WIDTH(8), .MODE(RAS_LIFO), .OVERWRITE(1'b1)) u_l1 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .dout(dout[3]),
    .empty(empty[3]), .full(full[3]), .count(count[3]), .overflow(ovf[3]),
    .underflow(unf[3]), .clr_err(clr_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0;
    pop = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    din = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    exp0.delete();
    exp1.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (empty[i] !== 1'b1 || full[i] !== 1'b0 || count[i] !== 3'd0 ||
          ovf[i] !== 1'b0 || unf[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset inst%0d: got e=%b f=%b c=%0d o=%b u=%b, want e=1 f=0 c=0 o=0 u=0",
                 i, empty[i], full[i], count[i], ovf[i], unf[i]);
      end
    end
  endtask

  task automatic test_fifo_order();
    logic [7:0] vals [3] = '{8'hA, 8'hB, 8'hC};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push = 1'b1;
      din = vals[k];
      exp0.push_back(vals[k]);
      tick();
      vectors++;
      if (count[0] !== 3'(k + 1)) begin
        miscompares++;
        $display("FAIL fifo_count_push%0d: got %0d want %0d", k, count[0], k + 1);
      end
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      pop = 1'b1;
      #1;
      e = exp0.pop_front();
      vectors++;
      if (dout[0] !== e) begin
        miscompares++;
        $display("FAIL fifo_order%0d: got %h want %h", k, dout[0], e);
      end
      tick();
      vectors++;
      if (count[0] !== 3'(2 - k)) begin
        miscompares++;
        $display("FAIL fifo_count_pop%0d: got %0d want %0d", k, count[0], 2 - k);
      end
    end
    idle();
    vectors++;
    if (empty[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_empty: got %b want 1", empty[0]);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    din = 8'h5;
    push = 1'b1;
    pop = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dout[i] !== 8'h5) begin
        miscompares++;
        $display("FAIL bypass_dout inst%0d: got %h want 05", i, dout[i]);
      end
    end
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (count[i] !== 3'd0 || ovf[i] !== 1'b0 || unf[i] !== 1'b0 || empty[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL bypass_state inst%0d: got c=%0d o=%b u=%b e=%b want c=0 o=0 u=0 e=1",
                 i, count[i], ovf[i], unf[i], empty[i]);
      end
    end
    pop = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (unf[i] !== 1'b1 || count[i] !== 3'd0) begin
        miscompares++;
        $display("FAIL underflow inst%0d: got u=%b c=%0d want u=1 c=0", i, unf[i], count[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      push = 1'b1;
      din = 8'(k);
      // Reject model for inst0, drop-oldest model for inst1.
      if (exp0.size() < 4) exp0.push_back(8'(k));
      if (exp1.size() == 4) void'(exp1.pop_front());
      exp1.push_back(8'(k));
      tick();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (full[i] !== 1'b1 || ovf[i] !== 1'b1 || count[i] !== 3'd4) begin
        miscompares++;
        $display("FAIL fifo_full inst%0d: got f=%b o=%b c=%0d want f=1 o=1 c=4",
                 i, full[i], ovf[i], count[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      pop = 1'b1;
      #1;
      e = exp0.pop_front();
      vectors++;
      if (dout[0] !== e) begin
        miscompares++;
        $display("FAIL fifo_reject_pop%0d: got %h want %h", k, dout[0], e);
      end
      e = exp1.pop_front();
      vectors++;
      if (dout[1] !== e) begin
        miscompares++;
        $display("FAIL fifo_overwrite_pop%0d: got %h want %h", k, dout[1], e);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lifo();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      push = 1'b1;
      din = 8'(k);
      exp0.push_back(8'(k));
      tick();
    end
    idle();
    vectors++;
    if (dout[2] !== exp0[$]) begin
      miscompares++;
      $display("FAIL lifo_top: got %h want %h", dout[2], exp0[$]);
    end
    push = 1'b1;
    pop = 1'b1;
    din = 8'h9;
    void'(exp0.pop_back());
    exp0.push_back(8'h9);
    tick();
    idle();
    vectors++;
    if (dout[2] !== 8'h9 || count[2] !== 3'd3) begin
      miscompares++;
      $display("FAIL lifo_replace: got d=%h c=%0d want d=09 c=3", dout[2], count[2]);
    end
    for (int k = 0; k < 3; k++) begin
      pop = 1'b1;
      #1;
      e = exp0.pop_back();
      vectors++;
      if (dout[2] !== e) begin
        miscompares++;
        $display("FAIL lifo_pop%0d: got %h want %h", k, dout[2], e);
      end
      tick();
    end
    idle();
    vectors++;
    if (empty[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL lifo_empty: got %b want 1", empty[2]);
    end
  endtask

  task automatic test_lifo_overwrite();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      push = 1'b1;
      din = 8'(k);
      if (exp1.size() == 4) void'(exp1.pop_front());
      exp1.push_back(8'(k));
      tick();
    end
    idle();
    vectors++;
    if (count[3] !== 3'd4 || ovf[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL lifo_ow_state: got c=%0d o=%b want c=4 o=1", count[3], ovf[3]);
    end
    for (int k = 0; k < 4; k++) begin
      pop = 1'b1;
      #1;
      e = exp1.pop_back();
      vectors++;
      if (dout[3] !== e) begin
        miscompares++;
        $display("FAIL lifo_ow_pop%0d: got %h want %h", k, dout[3], e);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_clear();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      push = 1'b1;
      din = 8'(k);
      tick();
    end
    idle();
    vectors++;
    if (count[0] !== 3'd3) begin
      miscompares++;
      $display("FAIL pre_reset_count: got %0d want 3", count[0]);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (count[0] !== 3'd0 || empty[0] !== 1'b1 || full[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got c=%0d e=%b f=%b want c=0 e=1 f=0",
               count[0], empty[0], full[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      push = 1'b1;
      din = 8'(k);
      tick();
    end
    idle();
    vectors++;
    if (ovf[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: got %b want 1", ovf[0]);
    end
    clr_err = 1'b1;
    tick();
    idle();
    vectors++;
    if (ovf[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_err: got %b want 0", ovf[0]);
    end
    clr_err = 1'b1;
    push = 1'b1;
    din = 8'h6;
    tick();
    idle();
    vectors++;
    if (ovf[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_vs_set: got %b want 1", ovf[0]);
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_bypass();
    test_fifo_full();
    test_lifo();
    test_lifo_overwrite();
    test_reset_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
